// File: rtl/uart_inst_loader_if.sv
// Serial-in / word-out bundle between the UART instruction loader and the fetch stage.
interface uart_inst_loader_if;
  logic        i_rx;
  logic [15:0] o_uart_inst;
  logic        o_uart_inst_en;
  logic        o_frame_err;

  modport master (
    input  i_rx,
    output o_uart_inst,
    output o_uart_inst_en,
    output o_frame_err
  );

  modport slave (
    output i_rx,
    input  o_uart_inst,
    input  o_uart_inst_en,
    input  o_frame_err
  );
endinterface

// File: rtl/uart_inst_loader.sv
// 8N1 UART receiver that pairs bytes (high byte first) into 16-bit instruction words
// with a one-cycle strobe; a stale high byte is dropped after an idle timeout.
module uart_inst_loader #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned TIMEOUT_CLKS = 20 * CLKS_PER_BIT
) (
  input  logic               clk,
  input  logic               reset,
  uart_inst_loader_if.master bus
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned TO_W  = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [TO_W-1:0]  TO_MAX  = TO_W'(TIMEOUT_CLKS);

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;

  logic             r_rx_meta, r_rx_s;
  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_tick, w_tick_nxt;
  logic [2:0]       r_bit_idx, w_bit_nxt;
  logic [7:0]       r_shift, w_shift_nxt;
  logic             w_byte_ok, w_ferr, w_start_entry;

  logic             r_phase_low;
  logic [7:0]       r_hold;
  logic [TO_W-1:0]  r_to_cnt;
  logic [15:0]      r_word;
  logic             r_word_en, r_frame_err;

  // Two-flop synchronizer; idle-high so reset does not fake a start bit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= bus.i_rx;
      r_rx_s    <= r_rx_meta;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_tick    <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_tick    <= w_tick_nxt;
      r_bit_idx <= w_bit_nxt;
      r_shift   <= w_shift_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_tick_nxt    = r_tick + CNT_W'(1);
    w_bit_nxt     = r_bit_idx;
    w_shift_nxt   = r_shift;
    w_byte_ok     = 1'b0;
    w_ferr        = 1'b0;
    w_start_entry = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_tick_nxt = '0;
        if (!r_rx_s) begin
          w_state_nxt   = ST_START;
          w_start_entry = 1'b1;
        end
      end
      ST_START: begin
        // Mid-start-bit check rejects glitches shorter than half a bit
        if (r_tick == HALF_M1) begin
          w_tick_nxt  = '0;
          w_bit_nxt   = '0;
          w_state_nxt = r_rx_s ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (r_tick == FULL_M1) begin
          w_tick_nxt  = '0;
          w_shift_nxt = {r_rx_s, r_shift[7:1]};
          if (r_bit_idx == 3'd7) w_state_nxt = ST_STOP;
          else                   w_bit_nxt   = r_bit_idx + 3'd1;
        end
      end
      ST_STOP: begin
        if (r_tick == FULL_M1) begin
          w_tick_nxt  = '0;
          w_state_nxt = ST_IDLE;
          w_byte_ok   = r_rx_s;
          w_ferr      = ~r_rx_s;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Word assembler with high-byte timeout; a new start bit outranks expiry
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_phase_low <= 1'b0;
      r_hold      <= '0;
      r_to_cnt    <= '0;
      r_word      <= '0;
      r_word_en   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_word_en   <= 1'b0;
      r_frame_err <= 1'b0;
      if (w_byte_ok) begin
        r_to_cnt <= '0;
        if (!r_phase_low) begin
          r_hold      <= r_shift;
          r_phase_low <= 1'b1;
        end else begin
          r_word      <= {r_hold, r_shift};
          r_word_en   <= 1'b1;
          r_phase_low <= 1'b0;
        end
      end else if (w_ferr) begin
        r_frame_err <= 1'b1;
        r_phase_low <= 1'b0;
        r_to_cnt    <= '0;
      end else if (!r_phase_low || w_start_entry) begin
        r_to_cnt <= '0;
      end else if (r_state == ST_IDLE) begin
        if (r_to_cnt >= TO_MAX) begin
          r_phase_low <= 1'b0;
          r_to_cnt    <= '0;
        end else begin
          r_to_cnt <= r_to_cnt + TO_W'(1);
        end
      end
    end
  end

  assign bus.o_uart_inst    = r_word;
  assign bus.o_uart_inst_en = r_word_en;
  assign bus.o_frame_err    = r_frame_err;

endmodule

// File: tb/tb_uart_inst_loader.sv
// Scoreboard bench for uart_inst_loader: directed UART frames in, expected words queued,
// a negedge monitor pops and compares each strobe.
module tb_uart_inst_loader;

  localparam int unsigned CPB = 8;
  localparam int unsigned TO  = 160;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  uart_inst_loader_if bus ();

  uart_inst_loader #(.CLKS_PER_BIT(CPB), .TIMEOUT_CLKS(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int          n_checks  = 0;
  int          n_errors  = 0;
  int          ferr_seen = 0;
  int          cyc       = 0;
  logic        prev_en   = 1'b0;
  logic [15:0] exp_q[$];
  int          t_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every strobe must match the head of the expected queue
  always @(negedge clk) begin
    if (bus.o_uart_inst_en === 1'b1) begin
      t_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_strobe: got word 0x%0h, expected no strobe", bus.o_uart_inst);
      end else begin
        check("word", 32'(bus.o_uart_inst), 32'(exp_q.pop_front()));
      end
      if (bus.o_frame_err === 1'b1) check("strobe_exclusive", 32'(bus.o_frame_err), 32'd0);
      if (prev_en === 1'b1) check("strobe_one_cycle", 32'(prev_en), 32'd0);
    end
    if (bus.o_frame_err === 1'b1) ferr_seen++;
    prev_en <= bus.o_uart_inst_en;
  end

  task automatic idle(input int n);
    bus.i_rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    bus.i_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.i_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    bus.i_rx = stop_bit;
    repeat (CPB) @(negedge clk);
    bus.i_rx = 1'b1;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 4000 && exp_q.size() != 0; i++) @(negedge clk);
    check(name, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    idle(4 * CPB);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_word"}, 32'(bus.o_uart_inst), 32'h0);
    check({tag, "_en"},   32'(bus.o_uart_inst_en), 32'd0);
    check({tag, "_ferr"}, 32'(bus.o_frame_err), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int f0;
    int t0;
    logic [7:0] lo;
    reset    = 1'b1;
    bus.i_rx = 1'b1;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    reset = 1'b0;
    idle(2 * CPB);

    // 1: back-to-back pair
    exp_q.push_back(16'h1234);
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b1);
    drain("t1_drain");
    check("t1_no_ferr", 32'(ferr_seen), 32'd0);

    // 2: two words with zero gaps, 20 bit-times apart
    t_q.delete();
    exp_q.push_back(16'hDEAD);
    exp_q.push_back(16'hBEEF);
    send_byte(8'hDE, 1'b1);
    send_byte(8'hAD, 1'b1);
    send_byte(8'hBE, 1'b1);
    send_byte(8'hEF, 1'b1);
    drain("t2_drain");
    check("t2_spacing", (t_q.size() == 2) ? 32'(t_q[1] - t_q[0]) : 32'hFFFF_FFFF, 32'(20 * CPB));

    // 3: bad stop bit discards the byte
    f0 = ferr_seen;
    send_byte(8'hAA, 1'b0);
    idle(2 * CPB);
    check("t3_ferr_pulse", 32'(ferr_seen - f0), 32'd1);
    exp_q.push_back(16'h5678);
    send_byte(8'h56, 1'b1);
    send_byte(8'h78, 1'b1);
    drain("t3_drain");

    // 4: short glitch, then high byte that times out
    t0 = t_q.size();
    f0 = ferr_seen;
    bus.i_rx = 1'b0;
    repeat (2) @(negedge clk);
    idle(4 * CPB);
    check("t4_glitch_no_strobe", 32'(t_q.size() - t0), 32'd0);
    check("t4_glitch_no_ferr", 32'(ferr_seen - f0), 32'd0);
    exp_q.push_back(16'hABCD);
    send_byte(8'h99, 1'b1);
    idle(200);
    check("t4_timeout_no_strobe", 32'(t_q.size() - t0), 32'd0);
    send_byte(8'hAB, 1'b1);
    send_byte(8'hCD, 1'b1);
    drain("t4_drain");
    check("t4_one_strobe", 32'(t_q.size() - t0), 32'd1);

    // 5: reset in data bit 3 of the low byte
    t0 = t_q.size();
    lo = 8'h57;
    send_byte(8'h13, 1'b1);
    bus.i_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      bus.i_rx = lo[i];
      repeat (CPB) @(negedge clk);
    end
    bus.i_rx = lo[3];
    repeat (CPB / 2) @(negedge clk);
    reset    = 1'b1;
    bus.i_rx = 1'b1;
    repeat (4) @(negedge clk);
    check_outputs_zero("t5_in_reset");
    reset = 1'b0;
    idle(12 * CPB);
    check_outputs_zero("t5_after_reset");
    check("t5_no_strobe", 32'(t_q.size() - t0), 32'd0);
    exp_q.push_back(16'h2468);
    send_byte(8'h24, 1'b1);
    send_byte(8'h68, 1'b1);
    drain("t5_drain");

    check("total_ferr", 32'(ferr_seen), 32'd1);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_inst_loader.md
# uart_inst_loader

Serial front end for the instruction-load path: it receives 8N1 UART bytes on one pin and pairs them into 16-bit words. Each completed word is presented on `o_uart_inst` with a one-cycle `o_uart_inst_en` strobe, which drives the fetch stage's `uart_instF` / `uart_inst_enF` inputs. It is the producing end of that interface, and bytes arrive high byte first.

## Interface

- `CLKS_PER_BIT`, default 434: clock cycles per UART bit (50 MHz / 115200). Legal range is 4 or more; even values only.
- `TIMEOUT_CLKS`, default 20 × `CLKS_PER_BIT`: maximum idle gap allowed between the high byte and the low byte of one word.
- `clk`, input, 1: single clock domain, rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `i_rx`, input, 1: UART line. Asynchronous to `clk`; idle level is high.
- `o_uart_inst`, output, 16: assembled word, `{high_byte, low_byte}`.
- `o_uart_inst_en`, output, 1: one-cycle strobe, asserted when `o_uart_inst` has just been updated.
- `o_frame_err`, output, 1: one-cycle strobe for a bad stop bit.

## Operation

- **Input synchronizer.** `i_rx` passes through a 2-FF synchronizer, giving `rx_s`. Both flops reset to 1. All logic below sees only `rx_s`.
- **Receive FSM states.** IDLE, START, DATA, STOP.
  - **IDLE:** when `rx_s` is 0, go to START and clear the bit-timer.
  - **START:** wait `CLKS_PER_BIT/2` cycles, then sample.
    - Sample 0: go to DATA and clear the bit-timer.
    - Sample 1: this is a false start (glitch). Return to IDLE with no outputs.
  - **DATA:** sample every `CLKS_PER_BIT` cycles, 8 samples, LSB first, into the shift register. A 3-bit bit index counts 0 to 7. After index 7, go to STOP.
  - **STOP:** sample once after `CLKS_PER_BIT` cycles, then return to IDLE unconditionally. IDLE is entered at mid-stop-bit, so back-to-back frames with no idle gap are accepted.
    - Stop sample 1: the byte is valid and goes to the word assembler.
    - Stop sample 0: pulse `o_frame_err`, discard the byte, and force the byte phase to HIGH.
- **Word assembler.** A byte-phase flag (HIGH or LOW) plus an 8-bit high-byte holding register.
  - A valid byte in HIGH phase is stored into the holding register; the phase becomes LOW and the timeout counter starts.
  - A valid byte in LOW phase causes `o_uart_inst <= {hold, byte}` and `o_uart_inst_en <= 1` for one cycle; the phase returns to HIGH.
- **Timeout.**
  - While in LOW phase, a counter increments every cycle the FSM is in IDLE. It resets to 0 on any START entry.
  - When it reaches `TIMEOUT_CLKS`, the phase reverts to HIGH and the held byte is dropped silently, with no strobe.
- **Word hold.** `o_uart_inst` holds its value between strobes.
- **Reset values.**
  - `o_uart_inst` = 16'h0000, `o_uart_inst_en` = 0, `o_frame_err` = 0.
  - FSM = IDLE, phase = HIGH, holding register = 0, counters = 0.
- **Reset mid-frame.** All state clears immediately. The partial byte or word is discarded, with no strobe during or after reset. After release, reception resumes at the next falling edge seen while `rx_s` is in IDLE.

## Timing

- **Synchronizer latency.** `rx_s` lags `i_rx` by 2 clocks.
- **Sample points.** Relative to the first cycle `rx_s` = 0 (call it T0):
  - start sample at T0 + `CLKS_PER_BIT/2`;
  - data bit *k* at T0 + `CLKS_PER_BIT/2` + (*k*+1) × `CLKS_PER_BIT`;
  - stop sample at T0 + `CLKS_PER_BIT/2` + 9 × `CLKS_PER_BIT`.
- **Strobe timing.** `o_uart_inst_en` and `o_frame_err` are registered. They assert on the clock edge after the stop sample and last exactly one cycle.
- **Exclusivity.** The two strobes are never high in the same cycle.
- **Throughput.** One word per 20 bit-times at line rate, with no backpressure. The consumer must take the word in the strobe cycle.
- **Simultaneous events.** A timeout expiry and a START entry in the same cycle resolve in favour of START: the counter clears and the held byte is kept.

## Test plan

All scenarios use `CLKS_PER_BIT` = 8 and `TIMEOUT_CLKS` = 160.

1. **Back-to-back word.** Send bytes 0x12 then 0x34 back-to-back.
   - `o_uart_inst` = 0x1234, with a single `o_uart_inst_en` pulse 1 cycle after the second stop sample.
   - No `o_frame_err`.
2. **Consecutive words.** Send 4 bytes 0xDE 0xAD 0xBE 0xEF with zero idle gaps.
   - Two strobes, giving 0xDEAD then 0xBEEF, 20 bit-times apart.
3. **Framing error.** Send 0xAA with its stop bit driven 0, then 0x56, 0x78.
   - `o_frame_err` pulses once.
   - The next strobe gives 0x5678.
   - No strobe carries 0xAA.
4. **Glitch and timeout.**
   - Pull `i_rx` low for 2 cycles: no state change and no strobe.
   - Then send 0x99, idle 200 cycles, then 0xAB, 0xCD: exactly one strobe, with value 0xABCD.
5. **Reset mid-byte.** Assert `reset` during DATA bit 3 of the low byte of 0x1357.
   - No strobe; outputs read 0x0000 / 0 / 0.
   - After release, sending 0x24, 0x68 gives 0x2468.
